// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port integer register file.
// The typedefs use the default geometry. Parametrised modules size their own ports.
package regfile_pkg;

  localparam int XLEN_DEFAULT     = 32;
  localparam int NREGS_DEFAULT    = 32;
  localparam int AW_DEFAULT       = $clog2(NREGS_DEFAULT);
  localparam int NR_PORTS_DEFAULT = 2;
  localparam int NW_PORTS_DEFAULT = 1;

  localparam logic [AW_DEFAULT-1:0] REG_ZERO = '0;

  typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] xlen_t;

  typedef reg_addr_t [NR_PORTS_DEFAULT-1:0] rd_addr_arr_t;
  typedef xlen_t     [NR_PORTS_DEFAULT-1:0] rd_data_arr_t;
  typedef reg_addr_t [NW_PORTS_DEFAULT-1:0] wr_addr_arr_t;
  typedef xlen_t     [NW_PORTS_DEFAULT-1:0] wr_data_arr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Priority per bit: reset, then flush, then issue (set), then writeback (clear).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int NW_PORTS = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_en,
  input  logic [AW-1:0]                issue_addr,
  input  logic [NW_PORTS-1:0]          wr_en,
  input  logic [NW_PORTS-1:0][AW-1:0]  wr_addr,
  input  logic                         flush,
  output logic [NREGS-1:0]             busy,
  output logic                         any_busy
);

  logic [NREGS-1:0] r_busy;

  // Issue is applied after the writeback clears, so a new producer of the
  // same register keeps it pending. Bit 0 is forced low last.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_busy <= '0;
    end else begin
      for (int p = 0; p < NW_PORTS; p++) begin
        if (wr_en[p]) r_busy[wr_addr[p]] <= 1'b0;
      end
      if (issue_en) r_busy[issue_addr] <= 1'b1;
      r_busy[0] <= 1'b0;
    end
  end

  assign busy     = r_busy;
  assign any_busy = |r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass
// and a pending-write scoreboard used by issue for RAW hazard detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int NR_PORTS = 2,
  parameter int NW_PORTS = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NR_PORTS-1:0][AW-1:0]    rd_addr,
  output logic [NR_PORTS-1:0][XLEN-1:0]  rd_data,
  output logic [NR_PORTS-1:0]            rd_busy,
  input  logic [NW_PORTS-1:0]            wr_en,
  input  logic [NW_PORTS-1:0][AW-1:0]    wr_addr,
  input  logic [NW_PORTS-1:0][XLEN-1:0]  wr_data,
  input  logic                           issue_en,
  input  logic [AW-1:0]                  issue_addr,
  input  logic                           flush,
  output logic                           any_busy
);

  if ((NREGS < 2) || ((NREGS & (NREGS - 1)) != 0)) begin : g_chk_nregs
    $error("regfile_mp: NREGS must be a power of two and at least 2");
  end
  if ((NR_PORTS < 1) || (NR_PORTS > 4)) begin : g_chk_nr
    $error("regfile_mp: NR_PORTS must be in 1..4");
  end
  if ((NW_PORTS < 1) || (NW_PORTS > 2)) begin : g_chk_nw
    $error("regfile_mp: NW_PORTS must be in 1..2");
  end

  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] w_busy;

  // Ports are visited in ascending order so the highest-index port wins a
  // same-address collision. Entry 0 is cleared on reset and never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else begin
      for (int p = 0; p < NW_PORTS; p++) begin
        if (wr_en[p] && (wr_addr[p] != ZERO_A)) r_mem[wr_addr[p]] <= wr_data[p];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NW_PORTS (NW_PORTS),
    .AW       (AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .flush      (flush),
    .busy       (w_busy),
    .any_busy   (any_busy)
  );

  // A hit from a completing writeback both forwards its data and masks the
  // busy bit, so issue sees the register as ready in the writeback cycle.
  always_comb begin
    logic w_hit;
    rd_data = '0;
    rd_busy = '0;
    for (int r = 0; r < NR_PORTS; r++) begin
      w_hit      = 1'b0;
      rd_data[r] = r_mem[rd_addr[r]];
      for (int p = 0; p < NW_PORTS; p++) begin
        if (wr_en[p] && (wr_addr[p] == rd_addr[r]) && (rd_addr[r] != ZERO_A)) begin
          w_hit = 1'b1;
          if (BYPASS != 0) rd_data[r] = wr_data[p];
        end
      end
      rd_busy[r] = w_busy[rd_addr[r]] & ~((BYPASS != 0) & w_hit);
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: one bypassing and one non-bypassing regfile_mp share stimulus
// and are compared against an array-based reference model every cycle.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  rd_addr_arr_t rd_addr;
  logic [1:0][31:0] rd_data_b, rd_data_n;
  logic [1:0]   rd_busy_b, rd_busy_n;
  logic [1:0]   wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic         issue_en;
  reg_addr_t    issue_addr;
  logic         flush;
  logic         any_b, any_n;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NR_PORTS(2), .NW_PORTS(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
    .issue_addr(issue_addr), .flush(flush), .any_busy(any_b));

  regfile_mp #(.XLEN(32), .NREGS(32), .NR_PORTS(2), .NW_PORTS(2), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
    .issue_addr(issue_addr), .flush(flush), .any_busy(any_n));

  typedef struct packed {
    logic [1:0][31:0] d_b;
    logic [1:0][31:0] d_n;
    logic [1:0]       bz_b;
    logic [1:0]       bz_n;
    logic             any;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  logic [31:0] m_mem  [32];
  bit          m_busy [32];
  bit          m_valid = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
    end
  endfunction

  task automatic step(input bit r, input bit fl, input bit iss, input int ia,
                      input bit we0, input int wa0, input logic [31:0] wd0,
                      input bit we1, input int wa1, input logic [31:0] wd1,
                      input int ra0, input int ra1);
    exp_t e;
    rst = r; flush = fl; issue_en = iss; issue_addr = reg_addr_t'(ia);
    wr_en = {we1, we0};
    wr_addr[0] = 5'(wa0); wr_addr[1] = 5'(wa1);
    wr_data[0] = wd0;     wr_data[1] = wd1;
    rd_addr[0] = 5'(ra0); rd_addr[1] = 5'(ra1);

    if (m_valid) begin
      e = '0;
      for (int k = 0; k < 2; k++) begin
        int ra;
        bit hit;
        logic [31:0] fwd;
        ra  = (k == 0) ? ra0 : ra1;
        hit = 0;
        fwd = '0;
        if (ra != 0) begin
          if (we0 && wa0 == ra) begin hit = 1; fwd = wd0; end
          if (we1 && wa1 == ra) begin hit = 1; fwd = wd1; end
        end
        e.d_n[k]  = (ra == 0) ? 32'h0 : m_mem[ra];
        e.d_b[k]  = hit ? fwd : e.d_n[k];
        e.bz_n[k] = (ra != 0) && m_busy[ra];
        e.bz_b[k] = e.bz_n[k] && !hit;
      end
      for (int i = 0; i < 32; i++) if (m_busy[i]) e.any = 1'b1;
      exp_q.push_back(e);
    end

    if (r) begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
      m_valid = 1;
    end else begin
      if (we0 && wa0 != 0) m_mem[wa0] = wd0;
      if (we1 && wa1 != 0) m_mem[wa1] = wd1;
      if (fl) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else begin
        if (we0 && wa0 != 0) m_busy[wa0] = 0;
        if (we1 && wa1 != 0) m_busy[wa1] = 0;
        if (iss && ia != 0)  m_busy[ia]  = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_read(input int ra0, input int ra1);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, ra0, ra1);
  endtask

  // Monitor: outputs are valid every cycle; compare at the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("rd_data_byp[%0d]", k),   rd_data_b[k], e.d_b[k]);
          chk($sformatf("rd_data_nobyp[%0d]", k), rd_data_n[k], e.d_n[k]);
          chk($sformatf("rd_busy_byp[%0d]", k),   32'(rd_busy_b[k]), 32'(e.bz_b[k]));
          chk($sformatf("rd_busy_nobyp[%0d]", k), 32'(rd_busy_n[k]), 32'(e.bz_n[k]));
        end
        chk("any_busy_byp",   32'(any_b), 32'(e.any));
        chk("any_busy_nobyp", 32'(any_n), 32'(e.any));
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 0; issue_en = 0; issue_addr = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    idle_read(5, 0);
    // Write then read back, then reset clears data
    step(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0, 1, 2);
    idle_read(5, 0);
    step(1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 5, 0);
    idle_read(5, 0);
    // Address 0: write and issue are ignored
    step(0, 0, 1, 0, 1, 0, 32'h12345678, 0, 0, 32'h0, 0, 0);
    idle_read(0, 0);
    // Same-cycle write/read of reg 7
    step(0, 0, 0, 0, 1, 7, 32'hA5A5A5A5, 0, 0, 32'h0, 7, 0);
    idle_read(7, 0);
    // Two ports to reg 3: port 1 wins
    step(0, 0, 0, 0, 1, 3, 32'h1111, 1, 3, 32'h2222, 3, 3);
    idle_read(0, 3);
    // Scoreboard: issue, writeback+reissue, writeback alone
    step(0, 0, 1, 9, 0, 0, 32'h0, 0, 0, 32'h0, 9, 0);
    idle_read(9, 0);
    step(0, 0, 1, 9, 1, 9, 32'h99, 0, 0, 32'h0, 9, 0);
    idle_read(9, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 1, 9, 32'h9A, 9, 0);
    idle_read(9, 0);
    // Issue 2,4,6 then flush with issue of 8
    step(0, 0, 1, 2, 0, 0, 32'h0, 0, 0, 32'h0, 2, 0);
    step(0, 0, 1, 4, 0, 0, 32'h0, 0, 0, 32'h0, 2, 4);
    step(0, 0, 1, 6, 0, 0, 32'h0, 0, 0, 32'h0, 4, 6);
    step(0, 1, 1, 8, 0, 0, 32'h0, 0, 0, 32'h0, 6, 8);
    idle_read(8, 2);
    idle_read(4, 6);
    idle_read(3, 7);

    // Randomised traffic on a narrow address range to force collisions
    for (int n = 0; n < 2000; n++) begin
      bit r, fl, iss, we0, we1;
      int ia, wa0, wa1, ra0, ra1;
      r   = ($urandom_range(0, 99) == 0);
      fl  = ($urandom_range(0, 29) == 0);
      iss = ($urandom_range(0, 9) < 4);
      we0 = $urandom_range(0, 1);
      we1 = $urandom_range(0, 1);
      ia  = $urandom_range(0, 15);
      wa0 = $urandom_range(0, 15);
      wa1 = $urandom_range(0, 15);
      ra0 = ($urandom_range(0, 3) == 0) ? wa0 : $urandom_range(0, 15);
      ra1 = ($urandom_range(0, 3) == 0) ? wa1 : $urandom_range(0, 31);
      step(r, fl, iss, ia, we0, wa0, $urandom, we1, wa1, $urandom, ra0, ra1);
    end
    idle_read(0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
